// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive framer.
// Imported by the framer top and its CRC helper.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_HUNT      = 3'd1,
        ST_SFD       = 3'd2,
        ST_DATA      = 3'd3,
        ST_POST      = 3'd4,
        ST_DROP      = 3'd5
    } state_e;

    localparam logic [7:0] SFD_BYTE = 8'hD5;

    // The register is kept MSB-first while data bits enter LSB-first.
    // That is the bit-reversed view of the usual reflected CRC-32,
    // so the good-frame residue appears as C704DD7B rather than DEBB20E3.
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    localparam int ERR_CRC  = 0;
    localparam int ERR_RUNT = 1;
    localparam int ERR_OVER = 2;
    localparam int ERR_PHY  = 3;

    // One CRC step for a single serial data bit.
    function automatic logic [31:0] crc32_bit(
        input logic [31:0] crc,
        input logic        d
    );
        logic fb;
        fb = crc[31] ^ d;
        return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/eth_rx_framer_if.sv
// Frame-buffer write port and status/acknowledge handshake
// between the receive framer and the packet RAM / software side.
interface eth_rx_framer_if #(
    parameter int ADDR_W = 11
) ();

    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
    logic              o_status_valid;
    logic [ADDR_W:0]   o_frame_len;
    logic [3:0]        o_err;
    logic              i_ack;

    modport master (
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data,
        output o_status_valid,
        output o_frame_len,
        output o_err,
        input  i_ack
    );

    modport slave (
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data,
        input  o_status_valid,
        input  o_frame_len,
        input  o_err,
        output i_ack
    );

endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 advance by one byte, bits taken LSB first.
// The caller owns the CRC register.
module eth_crc32_byte
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Unrolled serial update over the eight data bits.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            crc_next = crc32_bit(crc_next, data[i]);
        end
    end

endmodule

// File: rtl/eth_rx_framer.sv
// Ethernet receive framer: SFD hunt, byte assembly, buffer writes,
// on-the-fly CRC-32 and a per-frame status word with acknowledge.
module eth_rx_framer
    import eth_rx_pkg::*;
#(
    parameter int PHY_W   = 2,
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 1536,
    parameter int MIN_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sample_en,
    input  logic [PHY_W-1:0]   i_rxd,
    input  logic               i_rx_dv,
    input  logic               i_rx_er,
    eth_rx_framer_if.master    bus,
    output logic [CNT_W-1:0]   o_drop_cnt,
    output logic               o_busy
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [1:0] SYM_LAST = 2'(8 / PHY_W - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

    state_e             state;
    logic [7:0]         sr;
    logic [7:0]         sr_nx;
    logic [1:0]         sym_cnt;
    logic [LEN_W-1:0]   len;
    logic [31:0]        crc;
    logic [31:0]        crc_nx;
    logic               over_f;
    logic               phy_f;
    logic               byte_done;
    logic               byte_keep;
    logic               hunt_hit;
    logic [3:0]         post_err;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic               status_valid;
    logic [LEN_W-1:0]   frame_len;
    logic [3:0]         err;
    logic [CNT_W-1:0]   drop_cnt;

    assign sr_nx = {i_rxd, sr[7:PHY_W]};

    assign byte_done = (state == ST_DATA) && i_sample_en
                       && i_rx_dv && (sym_cnt == SYM_LAST);
    assign byte_keep = byte_done && (len < LEN_MAX);
    assign hunt_hit  = (state == ST_HUNT) && i_sample_en && i_rx_dv;

    eth_crc32_byte u_crc (
        .crc      (crc),
        .data     (sr_nx),
        .crc_next (crc_nx)
    );

    // Error word captured when a frame closes.
    always_comb begin
        post_err           = '0;
        post_err[ERR_CRC]  = (crc != CRC_RESIDUE);
        post_err[ERR_RUNT] = (len < LEN_MIN);
        post_err[ERR_OVER] = over_f;
        post_err[ERR_PHY]  = phy_f || (sym_cnt != 2'd0);
    end

    // Frame state machine with shift register, length and CRC tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_WAIT_IDLE;
            sr      <= '0;
            sym_cnt <= '0;
            len     <= '0;
            crc     <= '0;
            over_f  <= 1'b0;
            phy_f   <= 1'b0;
        end else begin
            unique case (state)
                ST_WAIT_IDLE: begin
                    if (i_sample_en && !i_rx_dv)
                        state <= ST_HUNT;
                end
                ST_HUNT: begin
                    sr <= '0;
                    if (hunt_hit) begin
                        if (status_valid) begin
                            state <= ST_DROP;
                        end else begin
                            state <= ST_SFD;
                            sr    <= {i_rxd, {(8 - PHY_W){1'b0}}};
                        end
                    end
                end
                ST_SFD: begin
                    if (i_sample_en) begin
                        if (!i_rx_dv) begin
                            state <= ST_HUNT;
                        end else begin
                            sr <= sr_nx;
                            if (sr_nx == SFD_BYTE) begin
                                state   <= ST_DATA;
                                sym_cnt <= '0;
                                len     <= '0;
                                crc     <= CRC_INIT;
                                over_f  <= 1'b0;
                                phy_f   <= 1'b0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (i_sample_en) begin
                        if (!i_rx_dv) begin
                            state <= ST_POST;
                        end else begin
                            sr <= sr_nx;
                            if (i_rx_er)
                                phy_f <= 1'b1;
                            if (sym_cnt == SYM_LAST) begin
                                sym_cnt <= '0;
                                crc     <= crc_nx;
                                if (len != LEN_SAT)
                                    len <= len + 1'b1;
                                if (len >= LEN_MAX)
                                    over_f <= 1'b1;
                            end else begin
                                sym_cnt <= sym_cnt + 2'd1;
                            end
                        end
                    end
                end
                ST_POST: begin
                    state <= ST_HUNT;
                end
                ST_DROP: begin
                    if (i_sample_en && !i_rx_dv)
                        state <= ST_HUNT;
                end
                default: begin
                    state <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    // Buffer write strobe, one cycle after the last symbol of a byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= byte_keep;
            if (byte_keep) begin
                wr_addr <= len[ADDR_W-1:0];
                wr_data <= sr_nx;
            end
        end
    end

    // Status word: posted on frame close, cleared by acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_valid <= 1'b0;
            frame_len    <= '0;
            err          <= '0;
        end else if (state == ST_POST) begin
            status_valid <= 1'b1;
            frame_len    <= len;
            err          <= post_err;
        end else if (bus.i_ack && status_valid) begin
            status_valid <= 1'b0;
            frame_len    <= '0;
            err          <= '0;
        end
    end

    // Saturating count of frames refused while a status is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (hunt_hit && status_valid && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign o_busy     = (state == ST_SFD) || (state == ST_DATA);
    assign o_drop_cnt = drop_cnt;

    assign bus.o_wr_en        = wr_en;
    assign bus.o_wr_addr      = wr_addr;
    assign bus.o_wr_data      = wr_data;
    assign bus.o_status_valid = status_valid;
    assign bus.o_frame_len    = frame_len;
    assign bus.o_err          = err;

endmodule
